sni_hostname_extractor: RTL and testbench
=========================================

# sni_hostname_extractor

Upstream parser for the SNI pattern-match stage. Consumes a TLS record byte stream at 2 bytes/cycle, walks the ClientHello to the server_name extension, and emits the hostname bytes as packed 16-bit words on the same valid/data pair that the per-protocol 2-bytes-per-cycle matchers consume. It realigns odd field offsets so the first hostname byte always lands in bits [15:8].

## Interface

Parameters:
- MAX_SNI_LEN, 255: longest accepted host_name length in bytes; a longer name is a parse error.
- PAD_BYTE, 8'h00: filler placed in [7:0] of the final word when the name length is odd.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous, active-high reset.
- i_data_valid, in, 1: input beat valid. No backpressure.
- i_data, in, 16: two stream bytes; [15:8] is the earlier byte.
- i_data_last, in, 1: last beat of the record.
- i_data_odd, in, 1: qualifies i_data_last; only [15:8] is valid.
- o_match_data_valid, out, 1: hostname word valid. Connects to the matcher's i_match_data_valid.
- o_match_data, out, 16: hostname bytes; [15:8] is the earlier byte.
- o_sni_last, out, 1: marks the final hostname word.
- o_sni_odd, out, 1: with o_sni_last, [7:0] is PAD_BYTE.
- o_no_sni, out, 1: 1-cycle pulse when the extensions end without server_name.
- o_parse_err, out, 1: 1-cycle pulse on truncation, an over-length name, or (with the macro) a bad type.

## Operation

- Byte-serial FSM. Each valid beat steps the FSM twice combinationally: [15:8] first, then [7:0]. [7:0] is skipped when i_data_last and i_data_odd are both set.
- A 16-bit skip/length counter and a 16-bit field-assembly register serve every field.
- States and transitions:
  - IDLE.
  - REC_HDR: 5 bytes.
  - HS_HDR: 4 bytes.
  - FIXED: 34 bytes of version + random.
  - SID_LEN (1 byte), then SKIP n.
  - CS_LEN (2 bytes), then SKIP n.
  - CM_LEN (1 byte), then SKIP n.
  - EXT_TOT: 2 bytes; loads the extension budget.
  - EXT_TYPE (2 bytes), then EXT_LEN (2 bytes). If the type is not 0x0000, SKIP EXT_LEN bytes and return to EXT_TYPE.
  - SNI_LIST: 2 bytes.
  - SNI_TYPE: 1 byte.
  - SNI_NLEN: 2 bytes.
  - SNI_NAME: N bytes.
  - DRAIN.
- The extension budget decrements on every byte after EXT_TOT. When the budget reaches 0 at an EXT_TYPE boundary, pulse o_no_sni and go to DRAIN.
- SNI_NLEN of 0 or greater than MAX_SNI_LEN: pulse o_parse_err, go to DRAIN, emit no words.
- Packing in SNI_NAME:
  - An 8-bit hold register plus a hold-valid flag pair name bytes.
  - Each complete pair produces a word.
  - On odd N, the last byte is paired with PAD_BYTE.
  - After the last name byte, go to DRAIN. DRAIN ignores bytes until i_data_last, then returns to IDLE.
- i_data_last in any state except IDLE or DRAIN: pulse o_parse_err and go to IDLE. A held half-word is discarded and o_sni_last is not asserted.
- i_data_last in DRAIN: go to IDLE.
- After an o_no_sni or o_parse_err decision, the FSM goes to DRAIN and waits for i_data_last.
- A beat may finish one field and start the next. Both bytes are always consumed.

## Timing

- All outputs are registered and reset to 0.
- o_match_data resets to 16'h0000.
- Latency: a word is presented one cycle after the input beat that supplies its second name byte (or PAD_BYTE).
- At most one word is produced per cycle.
- The output may gap when the name starts on an odd offset or the input gaps.
- o_sni_last and o_sni_odd are coincident with the final word's o_match_data_valid.
- o_no_sni and o_parse_err are single-cycle pulses, one cycle after the deciding beat.
- A beat with i_data_valid low changes nothing.
- i_rst takes priority over everything. One cycle later:
  - the FSM is in IDLE;
  - the counters and hold register are cleared;
  - all outputs are 0.
  A partial hostname is dropped with no o_sni_last.
- The first valid beat after i_data_last is treated as REC_HDR byte 0.

## Configuration

- SNI_STRICT_CHECK_EN defined: the following checks are enforced. Any mismatch pulses o_parse_err and the FSM goes to DRAIN.
  - Record type byte is 0x16.
  - Handshake type is 0x01.
  - SNI name type is 0x00.
  - SNI_LIST length equals SNI_NLEN + 3.
- Undefined: those bytes are skipped unchecked. The length and truncation checks still apply.

## Test plan

- Even-aligned name "xmpp.example.com" (N=16), session_id length 0, one cipher suite, no other extensions -> exactly 8 words: 0x786D, 0x7070, 0x2E65, 0x7861, 0x6D70, 0x6C65, 0x2E63, 0x6F6D. o_sni_last is set on the 8th word, o_sni_odd is 0, and no o_parse_err pulse occurs.
- Session_id length 1, so the name starts on an odd offset, name "a.io" -> words 0x612E and 0x696F, with the last word flagged. Each word appears 1 cycle after the beat carrying its second byte.
- Name "abc", PAD_BYTE=8'h00 -> words 0x6162 and 0x6300. o_sni_last and o_sni_odd are both set on 0x6300.
- Extensions hold only 0x000A (len 4) and 0x000D (len 2) -> o_no_sni pulses once, no words are emitted, and the FSM is idle after i_data_last.
- i_data_last arrives after 3 of 10 name bytes -> 1 word (bytes 0–1) is emitted, then o_parse_err pulses and o_sni_last is never asserted. The next record parses correctly.
- i_rst asserted mid-name, and, as a separate case, SNI_NLEN=300 with MAX_SNI_LEN=255 -> outputs are 0 one cycle after reset. The over-length case pulses o_parse_err with no words. With SNI_STRICT_CHECK_EN, a record type of 0x17 also pulses o_parse_err.

Source files
------------

// File: rtl/sni_hostname_extractor_if.sv
// Stream bus for the SNI hostname extractor: record bytes in, packed hostname
// words and status pulses out. The extractor is the slave; the record source
// and the downstream matcher together form the master side.
interface sni_hostname_extractor_if;
    logic        i_data_valid;
    logic [15:0] i_data;
    logic        i_data_last;
    logic        i_data_odd;
    logic        o_match_data_valid;
    logic [15:0] o_match_data;
    logic        o_sni_last;
    logic        o_sni_odd;
    logic        o_no_sni;
    logic        o_parse_err;

    modport slave (
        input  i_data_valid,
        input  i_data,
        input  i_data_last,
        input  i_data_odd,
        output o_match_data_valid,
        output o_match_data,
        output o_sni_last,
        output o_sni_odd,
        output o_no_sni,
        output o_parse_err
    );

    modport master (
        output i_data_valid,
        output i_data,
        output i_data_last,
        output i_data_odd,
        input  o_match_data_valid,
        input  o_match_data,
        input  o_sni_last,
        input  o_sni_odd,
        input  o_no_sni,
        input  o_parse_err
    );
endinterface

// File: rtl/sni_hostname_extractor.sv
// SNI hostname extractor.
// Walks a TLS ClientHello arriving two bytes per cycle, finds the server_name
// extension and re-packs the hostname into 16-bit words whose first byte
// always sits in [15:8], regardless of the byte offset the name started at.
// Optional macro SNI_STRICT_CHECK_EN: enables checking of the record type,
// handshake type, SNI name type and SNI list length; a mismatch is reported
// as a parse error. Without it those bytes are skipped unchecked.
module sni_hostname_extractor #(
    parameter int         MAX_SNI_LEN = 255,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    sni_hostname_extractor_if.slave       bus
);

    typedef enum logic [3:0] {
        IDLE,
        REC_HDR,
        HS_HDR,
        FIXED,
        SID_LEN,
        CS_LEN,
        CM_LEN,
        EXT_TOT,
        EXT_TYPE,
        EXT_LEN,
        SKIP,
        SNI_LIST,
        SNI_TYPE,
        SNI_NLEN,
        SNI_NAME,
        DRAIN
    } state_t;

    // Complete parser context; one byte step maps one context to the next.
    // cnt is a byte index inside fixed fields and a remaining-byte count in
    // SKIP and SNI_NAME. fld collects multi-byte length/type fields.
    typedef struct packed {
        state_t      state;
        state_t      retState;
        logic [15:0] cnt;
        logic [15:0] fld;
        logic [15:0] budget;
        logic [15:0] listLen;
        logic        extActive;
        logic        sniExt;
        logic [7:0]  hold;
        logic        holdValid;
    } ctx_t;

    // Events a single byte step can raise.
    typedef struct packed {
        logic        word;
        logic [15:0] data;
        logic        last;
        logic        odd;
        logic        noSni;
        logic        err;
    } ev_t;

    ctx_t        ctx_q, ctx_d;
    logic        matchValid_q, matchValid_d;
    logic [15:0] matchData_q, matchData_d;
    logic        sniLast_q, sniLast_d;
    logic        sniOdd_q, sniOdd_d;
    logic        noSni_q, noSni_d;
    logic        parseErr_q, parseErr_d;
    logic        pendValid_q, pendValid_d;
    logic [15:0] pendData_q, pendData_d;
    logic        pendOdd_q, pendOdd_d;

    ctx_t c1, c2;
    ev_t  e1, e2;

    // Advance the parser by one stream byte.
    function automatic void stepByte(input ctx_t cin, input logic [7:0] b,
                                     output ctx_t cout, output ev_t ev);
        logic [15:0] wide;
        logic        enterExt;
        logic        lastByte;
        cout     = cin;
        ev       = '0;
        enterExt = 1'b0;
        if (cin.state == IDLE) begin
            cout       = '0;
            cout.state = REC_HDR;
        end
        wide     = {cout.fld[7:0], b};
        lastByte = (cout.cnt == 16'd1);
        if (cout.extActive && cout.budget != 16'd0)
            cout.budget = cout.budget - 16'd1;

        case (cout.state)
            REC_HDR: begin
`ifdef SNI_STRICT_CHECK_EN
                if (cout.cnt == 16'd0 && b != 8'h16) ev.err = 1'b1;
`endif
                if (cout.cnt == 16'd4) begin
                    cout.state = HS_HDR;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.cnt = cout.cnt + 16'd1;
                end
            end
            HS_HDR: begin
`ifdef SNI_STRICT_CHECK_EN
                if (cout.cnt == 16'd0 && b != 8'h01) ev.err = 1'b1;
`endif
                if (cout.cnt == 16'd3) begin
                    cout.state = FIXED;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.cnt = cout.cnt + 16'd1;
                end
            end
            FIXED: begin
                if (cout.cnt == 16'd33) begin
                    cout.state = SID_LEN;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.cnt = cout.cnt + 16'd1;
                end
            end
            SID_LEN: begin
                if (b == 8'h00) begin
                    cout.state = CS_LEN;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.state    = SKIP;
                    cout.cnt      = {8'h00, b};
                    cout.retState = CS_LEN;
                end
            end
            CS_LEN: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else if (wide == 16'd0) begin
                    cout.state = CM_LEN;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.state    = SKIP;
                    cout.cnt      = wide;
                    cout.retState = CM_LEN;
                end
            end
            CM_LEN: begin
                if (b == 8'h00) begin
                    cout.state = EXT_TOT;
                    cout.cnt   = 16'd0;
                end else begin
                    cout.state    = SKIP;
                    cout.cnt      = {8'h00, b};
                    cout.retState = EXT_TOT;
                end
            end
            EXT_TOT: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else begin
                    cout.budget    = wide;
                    cout.extActive = 1'b1;
                    enterExt       = 1'b1;
                end
            end
            EXT_TYPE: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else begin
                    cout.sniExt = (wide == 16'h0000);
                    cout.state  = EXT_LEN;
                    cout.cnt    = 16'd0;
                end
            end
            EXT_LEN: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else if (cout.sniExt) begin
                    cout.state = SNI_LIST;
                    cout.cnt   = 16'd0;
                end else if (wide == 16'd0) begin
                    enterExt = 1'b1;
                end else begin
                    cout.state    = SKIP;
                    cout.cnt      = wide;
                    cout.retState = EXT_TYPE;
                end
            end
            SKIP: begin
                if (lastByte) begin
                    cout.cnt = 16'd0;
                    if (cout.retState == EXT_TYPE) enterExt = 1'b1;
                    else cout.state = cout.retState;
                end else begin
                    cout.cnt = cout.cnt - 16'd1;
                end
            end
            SNI_LIST: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else begin
                    cout.listLen = wide;
                    cout.state   = SNI_TYPE;
                    cout.cnt     = 16'd0;
                end
            end
            SNI_TYPE: begin
`ifdef SNI_STRICT_CHECK_EN
                if (b != 8'h00) ev.err = 1'b1;
`endif
                cout.state = SNI_NLEN;
                cout.cnt   = 16'd0;
            end
            SNI_NLEN: begin
                if (cout.cnt == 16'd0) begin
                    cout.fld = wide;
                    cout.cnt = 16'd1;
                end else begin
                    if (wide == 16'd0 || wide > 16'(MAX_SNI_LEN)) ev.err = 1'b1;
`ifdef SNI_STRICT_CHECK_EN
                    if (cout.listLen != wide + 16'd3) ev.err = 1'b1;
`endif
                    cout.state     = SNI_NAME;
                    cout.cnt       = wide;
                    cout.holdValid = 1'b0;
                end
            end
            SNI_NAME: begin
                if (cout.holdValid) begin
                    ev.word        = 1'b1;
                    ev.data        = {cout.hold, b};
                    ev.last        = lastByte;
                    cout.holdValid = 1'b0;
                end else if (lastByte) begin
                    ev.word = 1'b1;
                    ev.data = {b, PAD_BYTE};
                    ev.last = 1'b1;
                    ev.odd  = 1'b1;
                end else begin
                    cout.hold      = b;
                    cout.holdValid = 1'b1;
                end
                cout.cnt = cout.cnt - 16'd1;
                if (lastByte) cout.state = DRAIN;
            end
            default: begin
            end
        endcase

        if (enterExt) begin
            cout.state = EXT_TYPE;
            cout.cnt   = 16'd0;
            if (cout.budget == 16'd0) begin
                ev.noSni   = 1'b1;
                cout.state = DRAIN;
            end
        end
        if (ev.err) cout.state = DRAIN;
    endfunction

    // Run both bytes of a beat through the parser and work out the next
    // register values. A name ending on the low byte of a beat whose high byte
    // already completed a pair yields two words; the second is parked and sent
    // the following cycle so the output never carries more than one per cycle.
    always_comb begin
        c1           = ctx_q;
        c2           = ctx_q;
        e1           = '0;
        e2           = '0;
        ctx_d        = ctx_q;
        matchValid_d = 1'b0;
        matchData_d  = matchData_q;
        sniLast_d    = 1'b0;
        sniOdd_d     = 1'b0;
        noSni_d      = 1'b0;
        parseErr_d   = 1'b0;
        pendValid_d  = 1'b0;
        pendData_d   = pendData_q;
        pendOdd_d    = pendOdd_q;

        if (pendValid_q) begin
            matchValid_d = 1'b1;
            matchData_d  = pendData_q;
            sniLast_d    = 1'b1;
            sniOdd_d     = pendOdd_q;
        end

        if (bus.i_data_valid) begin
            stepByte(ctx_q, bus.i_data[15:8], c1, e1);
            if (bus.i_data_last && bus.i_data_odd) begin
                c2 = c1;
                e2 = '0;
            end else begin
                stepByte(c1, bus.i_data[7:0], c2, e2);
            end

            ctx_d      = c2;
            noSni_d    = e1.noSni | e2.noSni;
            parseErr_d = e1.err | e2.err;

            if (e1.word) begin
                matchValid_d = 1'b1;
                matchData_d  = e1.data;
                sniLast_d    = e1.last;
                sniOdd_d     = e1.odd;
                if (e2.word) begin
                    pendValid_d = 1'b1;
                    pendData_d  = e2.data;
                    pendOdd_d   = e2.odd;
                end
            end else if (e2.word) begin
                matchValid_d = 1'b1;
                matchData_d  = e2.data;
                sniLast_d    = e2.last;
                sniOdd_d     = e2.odd;
            end

            if (bus.i_data_last) begin
                if (c2.state != DRAIN) parseErr_d = 1'b1;
                ctx_d = '0;
            end
        end
    end

    // Parser context and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctx_q        <= '0;
            matchValid_q <= 1'b0;
            matchData_q  <= 16'h0000;
            sniLast_q    <= 1'b0;
            sniOdd_q     <= 1'b0;
            noSni_q      <= 1'b0;
            parseErr_q   <= 1'b0;
            pendValid_q  <= 1'b0;
            pendData_q   <= 16'h0000;
            pendOdd_q    <= 1'b0;
        end else begin
            ctx_q        <= ctx_d;
            matchValid_q <= matchValid_d;
            matchData_q  <= matchData_d;
            sniLast_q    <= sniLast_d;
            sniOdd_q     <= sniOdd_d;
            noSni_q      <= noSni_d;
            parseErr_q   <= parseErr_d;
            pendValid_q  <= pendValid_d;
            pendData_q   <= pendData_d;
            pendOdd_q    <= pendOdd_d;
        end
    end

    assign bus.o_match_data_valid = matchValid_q;
    assign bus.o_match_data       = matchData_q;
    assign bus.o_sni_last         = sniLast_q;
    assign bus.o_sni_odd          = sniOdd_q;
    assign bus.o_no_sni           = noSni_q;
    assign bus.o_parse_err        = parseErr_q;

endmodule

// File: tb/tb_sni_hostname_extractor.sv
// Directed bench for sni_hostname_extractor: builds ClientHello records byte by
// byte, streams them two bytes per cycle and compares the captured hostname
// words and status pulses against hand-computed values.
module tb_sni_hostname_extractor;

    logic i_clk = 1'b0;
    logic i_rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  txQ[$];
    logic [7:0]  nameQ[$];
    logic [15:0] expQ[$];
    int          beatCycQ[$];

    logic [15:0] wordQ[$];
    logic        lastQ[$];
    logic        oddQ[$];
    int          wordCycQ[$];
    int          noSniCnt = 0;
    int          errCnt = 0;
    int          lastCnt = 0;

    sni_hostname_extractor_if bus();

    sni_hostname_extractor #(
        .MAX_SNI_LEN(255),
        .PAD_BYTE(8'h00)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    // Cycle counter used to time words against the beats that produced them.
    always @(posedge i_clk) cyc <= cyc + 1;

    // Capture every output word and pulse on the falling edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (bus.o_match_data_valid) begin
                wordQ.push_back(bus.o_match_data);
                lastQ.push_back(bus.o_sni_last);
                oddQ.push_back(bus.o_sni_odd);
                wordCycQ.push_back(cyc);
            end
            if (bus.o_no_sni) noSniCnt <= noSniCnt + 1;
            if (bus.o_parse_err) errCnt <= errCnt + 1;
            if (bus.o_sni_last) lastCnt <= lastCnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push16(input int v);
        txQ.push_back(8'((v >> 8) & 255));
        txQ.push_back(8'(v & 255));
    endtask

    task automatic setName(input string s);
        nameQ.delete();
        for (int i = 0; i < s.len(); i++) nameQ.push_back(s[i]);
    endtask

    // mode 0: server_name extension with length nlen carrying nameQ bytes.
    // mode 1: only extensions 0x000A (len 4) and 0x000D (len 2).
    task automatic buildHello(input logic [7:0] recType, input int sidLen,
                              input int mode, input int nlen);
        txQ.delete();
        txQ.push_back(recType); txQ.push_back(8'h03); txQ.push_back(8'h01);
        push16(0);
        txQ.push_back(8'h01); txQ.push_back(8'h00); push16(0);
        txQ.push_back(8'h03); txQ.push_back(8'h03);
        for (int i = 0; i < 32; i++) txQ.push_back(8'hA5);
        txQ.push_back(8'(sidLen));
        for (int i = 0; i < sidLen; i++) txQ.push_back(8'h11);
        push16(2); push16(16'h1301);
        txQ.push_back(8'h02); txQ.push_back(8'h01); txQ.push_back(8'h00);
        if (mode == 0) begin
            push16(9 + nlen);
            push16(0); push16(nlen + 5); push16(nlen + 3);
            txQ.push_back(8'h00); push16(nlen);
            foreach (nameQ[i]) txQ.push_back(nameQ[i]);
        end else begin
            push16(14);
            push16(16'h000A); push16(4); push16(16'h0017); push16(16'h0018);
            push16(16'h000D); push16(2); push16(16'h0403);
        end
    endtask

    // Stream txQ two bytes per beat; maxBeats < 0 sends the whole record
    // with i_data_last, otherwise stops early without it.
    task automatic applyStimulus(input int maxBeats);
        int  n;
        int  beats;
        bit  full;
        n     = txQ.size();
        beats = (n + 1) / 2;
        full  = (maxBeats < 0);
        if (!full && maxBeats < beats) beats = maxBeats;
        beatCycQ.delete();
        for (int k = 0; k < beats; k++) begin
            @(posedge i_clk); #1;
            bus.i_data_valid   = 1'b1;
            bus.i_data[15:8]   = txQ[2*k];
            bus.i_data[7:0]    = (2*k + 1 < n) ? txQ[2*k+1] : 8'h00;
            bus.i_data_last    = full && (k == beats - 1);
            bus.i_data_odd     = full && (k == beats - 1) && (2*k + 1 >= n);
            beatCycQ.push_back(cyc);
        end
        @(posedge i_clk); #1;
        bus.i_data_valid = 1'b0;
        bus.i_data_last  = 1'b0;
        bus.i_data_odd   = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    // Compare words captured since index base against expQ; the final word
    // must carry o_sni_last and, if expOdd, o_sni_odd.
    task automatic checkWords(input string tag, input int base, input bit expOdd);
        logic [15:0] w;
        logic [1:0]  f;
        checkOutput($sformatf("%s_count", tag), wordQ.size() - base, expQ.size());
        foreach (expQ[i]) begin
            w = 'x;
            f = 'x;
            if (base + i < wordQ.size()) begin
                w = wordQ[base+i];
                f = {lastQ[base+i], oddQ[base+i]};
            end
            checkOutput($sformatf("%s_word%0d", tag, i), w, expQ[i]);
            checkOutput($sformatf("%s_flags%0d", tag, i), f,
                        (i == expQ.size() - 1) ? {1'b1, expOdd} : 2'b00);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {bus.o_match_data_valid, bus.o_match_data, bus.o_sni_last,
                          bus.o_sni_odd, bus.o_no_sni, bus.o_parse_err}, 32'h0);
    endtask

    task automatic loadXmppExp();
        expQ = '{16'h786D, 16'h7070, 16'h2E65, 16'h7861,
                 16'h6D70, 16'h6C65, 16'h2E63, 16'h6F6D};
    endtask

    initial begin
        int wb, eb, nb, lb;
        bus.i_data_valid = 1'b0;
        bus.i_data       = 16'h0000;
        bus.i_data_last  = 1'b0;
        bus.i_data_odd   = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkResetOutputs("reset_initial");
        i_rst = 1'b0;

        // Even-aligned 16-byte name.
        setName("xmpp.example.com");
        buildHello(8'h16, 0, 0, 16);
        wb = wordQ.size(); eb = errCnt; nb = noSniCnt;
        applyStimulus(-1);
        loadXmppExp();
        checkWords("xmpp", wb, 1'b0);
        checkOutput("xmpp_err", errCnt - eb, 0);
        checkOutput("xmpp_nosni", noSniCnt - nb, 0);

        // Odd offset (session_id of one byte), name "a.io" with latency check.
        setName("a.io");
        buildHello(8'h16, 1, 0, 4);
        wb = wordQ.size(); eb = errCnt;
        applyStimulus(-1);
        expQ = '{16'h612E, 16'h696F};
        checkWords("aio", wb, 1'b0);
        checkOutput("aio_lat0", (wordCycQ.size() > wb) ? wordCycQ[wb] : -1, beatCycQ[32] + 1);
        checkOutput("aio_lat1", (wordCycQ.size() > wb + 1) ? wordCycQ[wb+1] : -1, beatCycQ[33] + 1);
        checkOutput("aio_err", errCnt - eb, 0);

        // Odd-length name, even offset: padded last word.
        setName("abc");
        buildHello(8'h16, 0, 0, 3);
        wb = wordQ.size();
        applyStimulus(-1);
        expQ = '{16'h6162, 16'h6300};
        checkWords("abc_even", wb, 1'b1);

        // Odd-length name, odd offset: both words come from one beat.
        buildHello(8'h16, 1, 0, 3);
        wb = wordQ.size();
        applyStimulus(-1);
        checkWords("abc_odd", wb, 1'b1);
        checkOutput("abc_odd_lat1", (wordCycQ.size() > wb + 1) ? wordCycQ[wb+1] : -1, beatCycQ[32] + 2);

        // Extensions without server_name.
        buildHello(8'h16, 0, 1, 0);
        wb = wordQ.size(); eb = errCnt; nb = noSniCnt;
        applyStimulus(-1);
        checkOutput("nosni_pulse", noSniCnt - nb, 1);
        checkOutput("nosni_words", wordQ.size() - wb, 0);
        checkOutput("nosni_err", errCnt - eb, 0);

        // Record truncated after 3 of 10 name bytes, then a good record.
        setName("abc");
        buildHello(8'h16, 0, 0, 10);
        wb = wordQ.size(); eb = errCnt; lb = lastCnt;
        applyStimulus(-1);
        checkOutput("trunc_words", wordQ.size() - wb, 1);
        checkOutput("trunc_word0", (wordQ.size() > wb) ? wordQ[wb] : 16'hxxxx, 16'h6162);
        checkOutput("trunc_err", errCnt - eb, 1);
        checkOutput("trunc_nolast", lastCnt - lb, 0);
        setName("xmpp.example.com");
        buildHello(8'h16, 0, 0, 16);
        wb = wordQ.size();
        applyStimulus(-1);
        loadXmppExp();
        checkWords("after_trunc", wb, 1'b0);

        // Reset in the middle of a name.
        wb = wordQ.size(); lb = lastCnt;
        applyStimulus(33);
        checkOutput("rst_partial_words", wordQ.size() - wb, 2);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checkResetOutputs("reset_midname");
        i_rst = 1'b0;
        checkOutput("rst_nolast", lastCnt - lb, 0);
        wb = wordQ.size();
        applyStimulus(-1);
        checkWords("after_rst", wb, 1'b0);

        // Over-length name.
        nameQ.delete();
        buildHello(8'h16, 0, 0, 300);
        wb = wordQ.size(); eb = errCnt;
        applyStimulus(-1);
        checkOutput("overlen_err", errCnt - eb, 1);
        checkOutput("overlen_words", wordQ.size() - wb, 0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checkResetOutputs("reset_overlen");
        i_rst = 1'b0;

        // Non-handshake record type.
        setName("xmpp.example.com");
        buildHello(8'h17, 0, 0, 16);
        wb = wordQ.size(); eb = errCnt;
        applyStimulus(-1);
`ifdef SNI_STRICT_CHECK_EN
        checkOutput("rectype_err", errCnt - eb, 1);
        checkOutput("rectype_words", wordQ.size() - wb, 0);
`else
        checkOutput("rectype_err", errCnt - eb, 0);
        checkOutput("rectype_words", wordQ.size() - wb, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
